// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two SRAM-like masters (instruction, data) sharing one
// SRAM-like downstream port. Data normally wins; a starve counter forces an
// instruction grant after STARVE_LIMIT consecutive data grants. An in-order
// ID FIFO routes each downstream data_ok back to the port that issued it.
module sram_like_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     resetn,

  input  logic                     inst_req,
  input  logic                     inst_wr,
  input  logic [1:0]               inst_size,
  input  logic [3:0]               inst_wstrb,
  input  logic [31:0]              inst_addr,
  input  logic [31:0]              inst_wdata,
  output logic                     inst_addr_ok,
  output logic                     inst_data_ok,
  output logic [31:0]              inst_rdata,

  input  logic                     data_req,
  input  logic                     data_wr,
  input  logic [1:0]               data_size,
  input  logic [3:0]               data_wstrb,
  input  logic [31:0]              data_addr,
  input  logic [31:0]              data_wdata,
  output logic                     data_addr_ok,
  output logic                     data_data_ok,
  output logic [31:0]              data_rdata,

  output logic                     m_req,
  output logic                     m_wr,
  output logic [1:0]               m_size,
  output logic [3:0]               m_wstrb,
  output logic [31:0]              m_addr,
  output logic [31:0]              m_wdata,
  input  logic                     m_addr_ok,
  input  logic                     m_data_ok,
  input  logic [31:0]              m_rdata,

  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_spurious
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_INST,
    HOLD_DATA
  } state_t;

  state_t          state;
  logic            sel_data;
  logic            sel_req;
  logic            starved;
  logic            full;
  logic            empty;
  logic            handshake;
  logic            pop;
  logic            head_is_data;
  logic [SW-1:0]   starve_cnt;
  logic [DEPTH-1:0] id_fifo;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Source selection: a held source stays locked; otherwise data wins unless inst is starved
  always_comb begin
    starved  = (starve_cnt == SW'(STARVE_LIMIT)) && inst_req;
    sel_data = 1'b0;
    case (state)
      HOLD_INST: sel_data = 1'b0;
      HOLD_DATA: sel_data = 1'b1;
      default:   sel_data = starved ? 1'b0 : data_req;
    endcase
  end

  // Downstream request fields mux from the selected source
  always_comb begin
    sel_req = inst_req;
    m_wr    = inst_wr;
    m_size  = inst_size;
    m_wstrb = inst_wstrb;
    m_addr  = inst_addr;
    m_wdata = inst_wdata;
    if (sel_data) begin
      sel_req = data_req;
      m_wr    = data_wr;
      m_size  = data_size;
      m_wstrb = data_wstrb;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end
  end

  // Request/response routing; full is judged on the registered count only,
  // so m_data_ok never reaches m_req combinationally
  always_comb begin
    full         = (outstanding == (PW + 1)'(DEPTH));
    empty        = (outstanding == '0);
    m_req        = sel_req & ~full & resetn;
    handshake    = m_req & m_addr_ok;
    inst_addr_ok = handshake & ~sel_data;
    data_addr_ok = handshake & sel_data;
    pop          = m_data_ok & ~empty;
    head_is_data = id_fifo[rd_ptr];
    inst_data_ok = pop & ~head_is_data;
    data_data_ok = pop & head_is_data;
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
  end

  // Grant FSM: lock the selected source while the downstream stalls its address phase
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else if (handshake) begin
      state <= IDLE;
    end else if (m_req) begin
      state <= sel_data ? HOLD_DATA : HOLD_INST;
    end
  end

  // Starve counter: counts back-to-back data grants while inst is waiting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (handshake && !sel_data) begin
      starve_cnt <= '0;
    end else if (!inst_req) begin
      starve_cnt <= '0;
    end else if (handshake && sel_data && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // In-order ID FIFO with wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_fifo     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (handshake) begin
        id_fifo[wr_ptr] <= sel_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({handshake, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky flag for a downstream response with nothing outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_spurious <= 1'b0;
    end else if (m_data_ok && empty) begin
      err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;
  localparam logic [31:0] IA  = 32'h1000_0040;
  localparam logic [31:0] DA  = 32'h2000_0080;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [3:0]  inst_wstrb, data_wstrb, m_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [$clog2(DEPTH):0] outstanding;
  logic        err_spurious;

  always #5 clk = ~clk;

  sram_like_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ir, input logic dr, input logic aok, input logic dok);
    inst_req  = ir;
    data_req  = dr;
    m_addr_ok = aok;
    m_data_ok = dok;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: queue of issuing ports in acceptance order
  bit mq[$];
  int lock;      // -1 none, 0 inst, 1 data
  int starve;
  bit merr;

  task automatic model_reset;
    mq.delete();
    lock   = -1;
    starve = 0;
    merr   = 1'b0;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    #3;
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk1("rst_data_data_ok", data_data_ok, 1'b0);
    chk32("rst_outstanding", 32'(outstanding), 32'd0);
    chk1("rst_err", err_spurious, 1'b0);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    chk32("post_rst_outstanding", 32'(outstanding), 32'd0);
    chk1("post_rst_err", err_spurious, 1'b0);
    next_cycle();
  endtask

  typedef struct {
    logic [3:0] in;   // {inst_req, data_req, m_addr_ok, m_data_ok}
    logic [5:0] ex;   // {m_req, sel_data, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    int         out;  // outstanding before the edge
  } vec_t;

  function automatic vec_t v(input logic [3:0] in, input logic [5:0] ex, input int out);
    vec_t r;
    r.in  = in;
    r.ex  = ex;
    r.out = out;
    return r;
  endfunction

  task automatic rand_cycle;
    bit seld;
    bit ereq, hs, pop, head;
    inst_req   = ($urandom_range(0, 99) < 60);
    data_req   = ($urandom_range(0, 99) < 60);
    m_addr_ok  = ($urandom_range(0, 99) < 50);
    m_data_ok  = (mq.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
    inst_addr  = $urandom;  inst_wdata = $urandom;
    data_addr  = $urandom;  data_wdata = $urandom;
    inst_wstrb = 4'($urandom); data_wstrb = 4'($urandom);
    inst_size  = 2'($urandom); data_size  = 2'($urandom);
    inst_wr    = 1'($urandom); data_wr    = 1'($urandom);
    m_rdata    = $urandom;
    @(negedge clk);
    if (lock >= 0)                                seld = (lock == 1);
    else if (starve >= STARVE_LIMIT && inst_req)  seld = 1'b0;
    else                                          seld = data_req;
    ereq = (seld ? data_req : inst_req) && (mq.size() < DEPTH);
    hs   = ereq && m_addr_ok;
    pop  = m_data_ok && (mq.size() > 0);
    head = (mq.size() > 0) ? mq[0] : 1'b0;
    chk1("r_m_req", m_req, ereq);
    chk32("r_m_addr", m_addr, seld ? data_addr : inst_addr);
    chk32("r_m_wdata", m_wdata, seld ? data_wdata : inst_wdata);
    chk32("r_m_ctl", {25'd0, m_wr, m_size, m_wstrb},
          seld ? {25'd0, data_wr, data_size, data_wstrb} : {25'd0, inst_wr, inst_size, inst_wstrb});
    chk1("r_inst_addr_ok", inst_addr_ok, hs && !seld);
    chk1("r_data_addr_ok", data_addr_ok, hs && seld);
    chk1("r_inst_data_ok", inst_data_ok, pop && !head);
    chk1("r_data_data_ok", data_data_ok, pop && head);
    chk32("r_inst_rdata", inst_rdata, m_rdata);
    chk32("r_data_rdata", data_rdata, m_rdata);
    chk32("r_outstanding", 32'(outstanding), 32'(mq.size()));
    chk1("r_err", err_spurious, merr);
    @(posedge clk);
    if (m_data_ok && mq.size() == 0) merr = 1'b1;
    if (pop) void'(mq.pop_front());
    if (hs) mq.push_back(seld);
    if (hs) lock = -1;
    else if (ereq) lock = seld ? 1 : 0;
    if (hs && !seld) starve = 0;
    else if (!inst_req) starve = 0;
    else if (hs && seld && starve < STARVE_LIMIT) starve++;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[13];
    bit exp_d;

    resetn = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    inst_wr = 1'b0; data_wr = 1'b1;
    inst_size = 2'd2; data_size = 2'd1;
    inst_wstrb = 4'hf; data_wstrb = 4'h3;
    inst_addr = IA; data_addr = DA;
    inst_wdata = 32'h1111_2222; data_wdata = 32'h3333_4444;
    m_rdata = 32'hCAFE_F00D;

    // Priority, address-phase hold, in-order response routing
    vt[0]  = v(4'b1110, 6'b110100, 0);
    vt[1]  = v(4'b0000, 6'b000000, 1);
    vt[2]  = v(4'b0001, 6'b000001, 1);
    vt[3]  = v(4'b1000, 6'b100000, 0);
    vt[4]  = v(4'b1100, 6'b100000, 0);
    vt[5]  = v(4'b1100, 6'b100000, 0);
    vt[6]  = v(4'b1110, 6'b101000, 0);
    vt[7]  = v(4'b0110, 6'b110100, 1);
    vt[8]  = v(4'b1010, 6'b101000, 2);
    vt[9]  = v(4'b0001, 6'b000010, 3);
    vt[10] = v(4'b0001, 6'b000001, 2);
    vt[11] = v(4'b0001, 6'b000010, 1);
    vt[12] = v(4'b0000, 6'b000000, 0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_in(vt[i].in[3], vt[i].in[2], vt[i].in[1], vt[i].in[0]);
      @(negedge clk);
      chk1("t_m_req", m_req, vt[i].ex[5]);
      chk32("t_m_addr", m_addr, vt[i].ex[4] ? DA : IA);
      chk1("t_inst_addr_ok", inst_addr_ok, vt[i].ex[3]);
      chk1("t_data_addr_ok", data_addr_ok, vt[i].ex[2]);
      chk1("t_inst_data_ok", inst_data_ok, vt[i].ex[1]);
      chk1("t_data_data_ok", data_data_ok, vt[i].ex[0]);
      chk32("t_outstanding", 32'(outstanding), 32'(vt[i].out));
      chk1("t_err", err_spurious, 1'b0);
      next_cycle();
    end

    // FIFO full suppresses m_req, even with a pop in the same cycle
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk1("full_fill_addr_ok", data_addr_ok, 1'b1);
      chk32("full_fill_out", 32'(outstanding), 32'(k));
      next_cycle();
    end
    @(negedge clk);
    chk1("full_m_req", m_req, 1'b0);
    chk1("full_addr_ok", data_addr_ok, 1'b0);
    chk32("full_out", 32'(outstanding), 32'(DEPTH));
    next_cycle();
    m_data_ok = 1'b1;
    @(negedge clk);
    chk1("full_pop_m_req", m_req, 1'b0);
    chk1("full_pop_data_ok", data_data_ok, 1'b1);
    next_cycle();
    m_data_ok = 1'b0;
    @(negedge clk);
    chk1("after_pop_m_req", m_req, 1'b1);
    chk32("after_pop_out", 32'(outstanding), 32'(DEPTH - 1));
    chk1("after_pop_addr_ok", data_addr_ok, 1'b1);
    next_cycle();

    // Starvation: D,D,D,I repeating with both ports always requesting
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      m_data_ok = (k > 0);
      exp_d = ((k % (STARVE_LIMIT + 1)) != STARVE_LIMIT);
      @(negedge clk);
      chk1("starve_data_grant", data_addr_ok, exp_d);
      chk1("starve_inst_grant", inst_addr_ok, !exp_d);
      chk32("starve_out", 32'(outstanding), (k == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end

    // Spurious response, then asynchronous reset mid-burst
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk1("spur_inst_data_ok", inst_data_ok, 1'b0);
    chk1("spur_data_data_ok", data_data_ok, 1'b0);
    next_cycle();
    m_data_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("spur_err_sticky", err_spurious, 1'b1);
      chk32("spur_out", 32'(outstanding), 32'd0);
      next_cycle();
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    chk32("burst_out", 32'(outstanding), 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk32("midrst_out", 32'(outstanding), 32'd0);
    chk1("midrst_err", err_spurious, 1'b0);
    chk1("midrst_addr_ok", data_addr_ok, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    resetn = 1'b1;
    @(negedge clk);
    chk1("stale_inst_data_ok", inst_data_ok, 1'b0);
    chk1("stale_data_data_ok", data_data_ok, 1'b0);
    next_cycle();
    m_data_ok = 1'b0;
    @(negedge clk);
    chk1("stale_err", err_spurious, 1'b1);
    chk32("stale_out", 32'(outstanding), 32'd0);
    next_cycle();

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: maximum accepted-but-unanswered transactions (power of 2, 2..16).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 3: consecutive data-port grants allowed while inst_req is pending.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear on resetn low, without waiting for a clock edge.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 inst_req, inst_wr  in  1 each  instruction-port request and write flag.
REQ-007 inst_size  in  2; inst_wstrb  in  4; inst_addr, inst_wdata  in  32 each  instruction-port request fields.
REQ-008 inst_addr_ok, inst_data_ok  out  1 each; inst_rdata  out  32  instruction-port responses.
REQ-009 data_req, data_wr  in  1 each; data_size  in  2; data_wstrb  in  4; data_addr, data_wdata  in  32 each  data-port request.
REQ-010 data_addr_ok, data_data_ok  out  1 each; data_rdata  out  32  data-port responses.
REQ-011 m_req, m_wr  out  1 each; m_size  out  2; m_wstrb  out  4; m_addr, m_wdata  out  32 each  shared downstream request.
REQ-012 m_addr_ok, m_data_ok  in  1 each; m_rdata  in  32  shared downstream responses.
REQ-013 outstanding  out  clog2(DEPTH)+1  count of accepted, unanswered transactions.
REQ-014 err_spurious  out  1  sticky flag: m_data_ok received with no transaction outstanding.

Function
REQ-015 Grant FSM states SHALL be IDLE, HOLD_INST, HOLD_DATA; reset state IDLE.
REQ-016 In IDLE, the selected source SHALL be data if data_req=1, otherwise inst; the starvation override (REQ-021) takes precedence over this.
REQ-017 If m_req=1 and m_addr_ok=0, the FSM SHALL enter HOLD_<selected>; in HOLD_x, source x SHALL stay selected, whatever the other port requests, until m_req & m_addr_ok.
REQ-018 On handshake (m_req & m_addr_ok), the FSM SHALL return to IDLE on the next edge.
REQ-019 m_req SHALL equal the selected source's req AND (outstanding < DEPTH); all m_* request fields SHALL be driven combinationally from the selected source.
REQ-020 x_addr_ok SHALL be m_addr_ok & m_req & (selected==x); the non-selected port's addr_ok SHALL be 0.
REQ-021 A starve counter SHALL increment on each data-port handshake while inst_req=1, clear on any inst-port handshake or when inst_req=0, and saturate at STARVE_LIMIT; at STARVE_LIMIT, IDLE SHALL select inst if inst_req=1.
REQ-022 Each handshake SHALL push a 1-bit source ID (0=inst, 1=data) into an in-order ID FIFO of DEPTH entries; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 On m_data_ok with FIFO non-empty, the head entry SHALL pop in the same cycle, and m_data_ok SHALL be routed combinationally to the head's port only (zero-cycle response latency).
REQ-024 inst_rdata and data_rdata SHALL both equal m_rdata unconditionally.
REQ-025 A push and a pop in the same cycle SHALL leave outstanding unchanged and SHALL move both pointers.
REQ-026 A full FIFO SHALL suppress m_req even if a pop occurs in the same cycle, so that no combinational path runs from m_data_ok to m_req.
REQ-027 m_data_ok with an empty FIFO SHALL be ignored (no port data_ok, no pointer change) and SHALL set err_spurious, which holds until reset.
REQ-028 Responses SHALL return strictly in acceptance order, regardless of source.

Reset
REQ-029 During and immediately after reset: FSM=IDLE, FIFO empty, outstanding=0, starve counter=0, err_spurious=0, all x_addr_ok/x_data_ok=0.
REQ-030 Reset asserted mid-transaction SHALL discard all outstanding IDs; post-reset m_data_ok for those transactions SHALL be treated per REQ-027.

Verification
REQ-031 The bench SHALL cover: inst_req=1, data_req=1, m_addr_ok=1 at cycle 0 -> m_addr=data_addr, data_addr_ok=1, inst_addr_ok=0; outstanding=1 at cycle 1.
REQ-032 The bench SHALL cover: inst_req alone, m_addr_ok=0 for 3 cycles, data_req rises in cycle 1 -> m_addr stays inst_addr through the cycle-3 handshake, then data is granted.
REQ-033 The bench SHALL cover: accept inst A, data B, inst C, then m_data_ok on 3 consecutive cycles -> inst_data_ok, data_data_ok, inst_data_ok in that order; outstanding 3->0.
REQ-034 The bench SHALL cover: DEPTH=4, 4 accepted with no response -> m_req=0 and outstanding=4; one m_data_ok -> m_req reasserts the next cycle.
REQ-035 The bench SHALL cover: both ports requesting continuously with m_addr_ok=1, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I.
REQ-036 The bench SHALL cover: m_data_ok with outstanding=0 -> no port data_ok and err_spurious=1 thereafter; resetn low mid-burst -> outstanding=0 and err_spurious=0 immediately.
